// File: rtl/burst_mem_bridge.sv
// burst_mem_bridge
//   Slave for CPU cache line fills and writebacks. Splits one burst command
//   (base byte address + word count) into single-word accesses on a downstream
//   word bus that uses one-cycle rd/we pulses answered by a ready pulse, and
//   returns one upstream ready pulse per transferred word.
//
// Parameters
//   WR_DATA_DELAY  cycles (>= 1) between a write issue / write ready pulse and
//                  the sampling of up_d; covers upstream sync-RAM read latency
//   ADDR_STEP      byte increment between successive words
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   up_burst_en      1: burst of up_burst_length words, 0: single word
//   up_burst_length  words per burst (0 = no transfer)
//   up_a             burst base byte address, sampled on the issue cycle
//   up_d             write data for the current word
//   up_we / up_rd    one-cycle write / read burst issue pulses (write wins)
//   up_spo           registered read data, held until the next word loads
//   up_ready         one-cycle per-word completion pulse
//   busy             high whenever the bridge is not idle
//   mem_a / mem_d    downstream word address / write data (hold between accesses)
//   mem_we / mem_rd  downstream one-cycle write / read pulses
//   mem_spo          downstream read data, valid while mem_ready is high
//   mem_ready        downstream completion pulse
//
// Optional build macro BURST_MEM_BRIDGE_PERF_EN adds saturating counters
//   perf_rd_bursts, perf_wr_bursts (accepted non-empty bursts) and
//   perf_stall_cycles (cycles spent waiting on mem_ready).
module burst_mem_bridge #(
  parameter int unsigned WR_DATA_DELAY = 2,
  parameter logic [31:0] ADDR_STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_burst_en,
  input  logic [7:0]  up_burst_length,
  input  logic [31:0] up_a,
  input  logic [31:0] up_d,
  input  logic        up_we,
  input  logic        up_rd,
  output logic [31:0] up_spo,
  output logic        up_ready,
  output logic        busy,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready
`ifdef BURST_MEM_BRIDGE_PERF_EN
  ,
  output logic [31:0] perf_rd_bursts,
  output logic [31:0] perf_wr_bursts,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_DELAY, WR_ISSUE, WR_WAIT
  } state_t;

  // The delay counter counts down to 1. After issue it covers WR_DATA_DELAY
  // cycles; after a ready it starts one higher because the ready cycle itself
  // is the reference point, not the cycle that saw mem_ready.
  localparam int unsigned DLY_W = $clog2(WR_DATA_DELAY + 2);
  localparam logic [DLY_W-1:0] DLY_FIRST = DLY_W'(WR_DATA_DELAY);
  localparam logic [DLY_W-1:0] DLY_NEXT  = DLY_W'(WR_DATA_DELAY + 1);

  state_t           state, state_next;
  logic [31:0]      base_q;
  logic [8:0]       len_q;      // 9 bits so that 255 + 1 compares correctly
  logic [8:0]       word_idx;
  logic [DLY_W-1:0] dly_cnt;

  logic [8:0]  eff_len;
  logic        start_rd, start_wr, word_done, last_word, dly_done;
  logic [31:0] next_offset;

  assign eff_len     = up_burst_en ? {1'b0, up_burst_length} : 9'd1;
  assign last_word   = (word_idx + 9'd1) == len_q;
  assign next_offset = {23'd0, word_idx + 9'd1} * ADDR_STEP;

  assign busy   = (state != IDLE);
  assign mem_rd = (state == RD_ISSUE);
  assign mem_we = (state == WR_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    word_done  = 1'b0;
    dly_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (eff_len != 9'd0) begin
          start_wr = up_we;
          start_rd = up_rd && !up_we;
        end
        if (start_wr)      state_next = WR_DELAY;
        else if (start_rd) state_next = RD_ISSUE;
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        word_done = mem_ready;
        if (mem_ready) state_next = last_word ? IDLE : RD_ISSUE;
      end
      WR_DELAY: begin
        dly_done = (dly_cnt == DLY_W'(1));
        if (dly_done) state_next = WR_ISSUE;
      end
      WR_ISSUE: state_next = WR_WAIT;
      WR_WAIT: begin
        word_done = mem_ready;
        if (mem_ready) state_next = last_word ? IDLE : WR_DELAY;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, including the datapath,
    // is cleared so an aborted burst leaves no stale address or data behind.
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      word_idx <= '0;
      dly_cnt  <= '0;
      mem_a    <= '0;
      mem_d    <= '0;
      up_spo   <= '0;
      up_ready <= 1'b0;
    end else begin
      up_ready <= word_done;
      if (start_rd || start_wr) begin
        base_q   <= up_a;
        len_q    <= eff_len;
        word_idx <= '0;
        mem_a    <= up_a;
        dly_cnt  <= DLY_FIRST;
      end
      if (word_done) begin
        word_idx <= word_idx + 9'd1;
        dly_cnt  <= DLY_NEXT;
        if (state == RD_WAIT) up_spo <= mem_spo;
        // mem_a keeps the final word's address once the burst is done
        if (!last_word) mem_a <= base_q + next_offset;
      end
      if (state == WR_DELAY) begin
        if (dly_done) mem_d   <= up_d;
        else          dly_cnt <= dly_cnt - DLY_W'(1);
      end
    end
  end

`ifdef BURST_MEM_BRIDGE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_bursts    <= '0;
      perf_wr_bursts    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (start_rd && perf_rd_bursts != '1) perf_rd_bursts <= perf_rd_bursts + 32'd1;
      if (start_wr && perf_wr_bursts != '1) perf_wr_bursts <= perf_wr_bursts + 32'd1;
      if ((state == RD_WAIT || state == WR_WAIT) && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/burst_mem_bridge.md
Name: burst_mem_bridge

Overview:
- Sits directly downstream of the CPU cache's lowmem port; it is the slave for cache line fills and writebacks.
- Converts one burst command (base address plus length) into a sequence of single-word accesses on the downstream word bus (memory controller / system bus with a one-cycle rd/we pulse and a ready pulse).
- Returns one upstream ready pulse per transferred word.

Parameters:
- WR_DATA_DELAY, 2: cycles after the write issue (or after each write ready pulse) before up_d is sampled. Covers the upstream synchronous-RAM read latency.
- ADDR_STEP, 4: byte increment between successive words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- up_burst_en  in  1  1: burst of up_burst_length words; 0: single word
- up_burst_length  in  8  words per burst; 0 means no transfer
- up_a  in  32  burst base byte address, sampled on the issue cycle
- up_d  in  32  write data for the current word
- up_we  in  1  one-cycle write-burst issue pulse
- up_rd  in  1  one-cycle read-burst issue pulse
- up_spo  out  32  registered read data
- up_ready  out  1  one-cycle per-word completion pulse
- busy  out  1  high whenever state is not IDLE
- mem_a  out  32  downstream word address
- mem_d  out  32  downstream write data
- mem_we  out  1  downstream write pulse
- mem_rd  out  1  downstream read pulse
- mem_spo  in  32  downstream read data, valid while mem_ready is high
- mem_ready  in  1  downstream completion pulse

Behaviour:
- Reset (clk, rst synchronous active-high):
  - state=IDLE; up_ready=0, up_spo=0, busy=0, mem_we=0, mem_rd=0, mem_a=0, mem_d=0.
  - Internal counter and latched base address cleared.
  - Reset mid-burst aborts immediately; no further ready pulses. A downstream mem_ready arriving after reset is ignored; the downstream block shares the same rst.
- Issue (IDLE only):
  - On up_rd or up_we, latch up_a and the effective length: up_burst_en ? up_burst_length : 1.
  - Effective length 0: remain in IDLE, no pulses.
  - up_we and up_rd in the same cycle: write wins; the read is dropped.
  - Issue pulses received while busy are ignored.
- Addressing:
  - Word k address = base + k*ADDR_STEP, 32-bit wrap-around (0xFFFFFFFC+4 -> 0x00000000).
  - The counter is 9 bits so a length of 255 terminates correctly.
- Read path, states IDLE -> RD_ISSUE -> RD_WAIT -> RD_ISSUE... -> IDLE:
  - RD_ISSUE: mem_rd=1 for exactly one cycle, mem_a = word address.
  - RD_WAIT: on mem_ready, register mem_spo into up_spo and pulse up_ready in the next cycle.
  - up_spo holds its value until the next word is loaded, so it is valid both in the up_ready cycle and in the cycle after.
  - up_ready pulses are therefore spaced at least 2 cycles apart.
  - After the last word: IDLE in the same cycle that up_ready pulses.
- Write path, states IDLE -> WR_DELAY -> WR_ISSUE -> WR_WAIT -> WR_DELAY... -> IDLE:
  - WR_DELAY: count WR_DATA_DELAY cycles from the issue cycle (or from the previous up_ready cycle), then sample up_d into mem_d.
  - WR_ISSUE: mem_we=1 for one cycle with mem_a and mem_d.
  - WR_WAIT: on mem_ready, pulse up_ready in the next cycle.
  - Upstream contract: word k data is stable from WR_DATA_DELAY cycles after the previous ready (or after issue) until its own ready.
  - After the last word: IDLE.
- Latency:
  - Read word: up_ready at mem_ready+1.
  - First mem_rd at issue+1; first mem_we at issue+WR_DATA_DELAY+1.
- mem_ready outside RD_WAIT/WR_WAIT is ignored.
- mem_d and mem_a hold their last value between accesses.

Optional Feature:
- Macro BURST_MEM_BRIDGE_PERF_EN.
- Defined: adds three 32-bit counters, each cleared by rst and saturating at 0xFFFFFFFF, exposed as outputs perf_rd_bursts, perf_wr_bursts and perf_stall_cycles.
  - perf_rd_bursts / perf_wr_bursts: incremented on each accepted non-zero-length issue.
  - perf_stall_cycles: incremented every cycle spent in RD_WAIT or WR_WAIT.
- Undefined: counters and ports absent; behaviour otherwise identical.

Test Plan:
- Read burst: up_rd, burst_en=1, length=4, a=0x1000; mem returns 0xA0..0xA3 with 1-cycle latency -> mem_rd at 0x1000/1004/1008/100C; 4 up_ready pulses each ≥2 cycles apart; up_spo=0xA0..0xA3 valid in the ready cycle and the cycle after; busy drops after the 4th pulse.
- Write burst: up_we, length=3, a=0x2000; upstream changes up_d to 0xB0/0xB1/0xB2 one cycle after issue and one cycle after each ready -> mem_we writes exactly those values to 0x2000/2004/2008; 3 up_ready pulses.
- Edge cases:
  - burst_en=0 read at 0xFFFFFFFC -> exactly one access and one ready pulse.
  - length=2 burst at 0xFFFFFFFC -> second address 0x00000000.
  - length=0 -> no mem activity, busy stays 0.
- Simultaneous up_we=up_rd=1 -> write burst only. up_rd pulsed mid-burst -> ignored, no extra mem_rd.
- Assert rst during the 2nd word of a length-8 read, with mem_ready arriving the cycle after -> all outputs at reset values, no up_ready, next burst issue completes normally.
- With BURST_MEM_BRIDGE_PERF_EN: 2 reads plus 1 write with a 3-cycle mem latency -> perf_rd_bursts=2, perf_wr_bursts=1, perf_stall_cycles matches the wait-cycle count.
